led_pwm_driver: RTL

- Downstream output stage for the board's LED blink/pattern logic: takes 4 on/off LED requests and drives the physical `F_LED[4:1]` pins.
- Applies a global 8-bit PWM brightness, or an automatic "breathing" ramp, per PWM period.
- Duty changes take effect only at period boundaries, so there are no mid-period glitches.

---
 rtl/led_pwm_if.sv | 11 +
 rtl/led_pwm_driver.sv | 91 +++++++++
 2 files changed

// File: rtl/led_pwm_if.sv
// led_pwm_if: LED request/brightness inputs and pin/status outputs of led_pwm_driver.
interface led_pwm_if;
  logic [3:0] led_req;
  logic [7:0] brightness;
  logic       breathe_en;
  logic [3:0] F_LED;
  logic       period_start;
  logic [7:0] breath_level;
  modport master (output led_req, brightness, breathe_en, input F_LED, period_start, breath_level);
  modport slave  (input led_req, brightness, breathe_en, output F_LED, period_start, breath_level);
endinterface

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: 4-LED PWM stage with static or breathing duty latched per period.
// Define LED_PWM_ACTIVE_LOW_EN to drive F_LED inverted (reset value 4'b1111).
module led_pwm_driver #(
  parameter int PRESC_DIV      = 196,
  parameter int BREATH_PERIODS = 4,
  parameter int BREATH_STEP    = 2,
  parameter int HOLD_STEPS     = 32
) (
  input logic FPGA_CLK,
  input logic FPGA_RST,
  led_pwm_if.slave bus
);
  localparam int PW = PRESC_DIV > 1 ? $clog2(PRESC_DIV) : 1;
  localparam int SW = BREATH_PERIODS > 1 ? $clog2(BREATH_PERIODS) : 1;
  localparam int HW = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
`ifdef LED_PWM_ACTIVE_LOW_EN
  localparam logic [3:0] LED_OFF = 4'hF;
`else
  localparam logic [3:0] LED_OFF = 4'h0;
`endif
  typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [SW-1:0] step_cnt, step_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [7:0] pwm_cnt, duty_q, level_n;
  logic [8:0] up9, dn9;
  logic tick, wrap, stp, hold_done;
  assign tick = presc == PW'(PRESC_DIV - 1);
  assign wrap = tick && pwm_cnt == 8'hFF;
  assign stp = step_cnt == SW'(BREATH_PERIODS - 1);
  assign hold_done = hold_cnt == HW'(HOLD_STEPS - 1);
  assign up9 = {1'b0, bus.breath_level} + 9'(BREATH_STEP);
  assign dn9 = {1'b0, bus.breath_level} - 9'(BREATH_STEP);
  // Deasserting breathe_en overrides everything, wrap or not
  always_comb begin
    state_n = state;
    level_n = bus.breath_level;
    step_n = wrap ? (stp ? '0 : step_cnt + 1'b1) : step_cnt;
    hold_n = hold_cnt;
    if (!bus.breathe_en) begin
      state_n = IDLE;
      level_n = '0;
      step_n = '0;
      hold_n = '0;
    end else if (wrap) begin
      case (state)
        IDLE: begin
          state_n = UP;
          step_n = '0;
          hold_n = '0;
        end
        UP: if (stp) begin
          level_n = up9 > 9'd255 ? 8'hFF : up9[7:0];
          state_n = up9 >= 9'd255 ? HOLD_HI : UP;
        end
        DOWN: if (stp) begin
          level_n = dn9[8] ? 8'h00 : dn9[7:0];
          state_n = (dn9[8] || dn9 == 9'd0) ? HOLD_LO : DOWN;
        end
        default: if (stp) begin
          hold_n = hold_done ? '0 : hold_cnt + 1'b1;
          state_n = hold_done ? (state == HOLD_HI ? DOWN : UP) : state;
        end
      endcase
    end
  end
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      presc <= '0;
      pwm_cnt <= '0;
      duty_q <= '0;
      state <= IDLE;
      step_cnt <= '0;
      hold_cnt <= '0;
      bus.F_LED <= LED_OFF;
      bus.period_start <= 1'b0;
      bus.breath_level <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 8'(tick);
      if (wrap) duty_q <= bus.breathe_en ? bus.breath_level : bus.brightness;
      state <= state_n;
      step_cnt <= step_n;
      hold_cnt <= hold_n;
      bus.F_LED <= LED_OFF ^ (bus.led_req & {4{pwm_cnt < duty_q}});
      bus.period_start <= wrap;
      bus.breath_level <= level_n;
    end
  end
endmodule
